mac_dot_pipe: RTL and testbench

- Parametrised successor to the single-lane 16-bit MAC: an integer dot-product accumulator with LANES parallel multipliers, a pipelined adder tree and a saturating accumulator.
- Sits between the operand feeder and the result writeback. Feeder side uses a valid/ready handshake; result side uses a held valid/ready handshake.
- Accumulation length is programmable per job; signed/unsigned is selectable per job.

---
 rtl/mac_dot_pipe.sv | 187 ++++++++++++++++++
 tb/tb_mac_dot_pipe.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_pipe.sv
// LANES-wide integer dot-product accumulator. Three stages: lane products, adder-tree sum, saturating accumulate.
// Jobs run IDLE -> RUN -> DRAIN -> DONE; o_dbg_state exposes the FSM state.
module mac_dot_pipe #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int ACC_W = 40,
  parameter int LEN_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_mode,
  input  logic [LEN_W-1:0]      acc_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*DW-1:0]   data_a,
  input  logic [LANES*DW-1:0]   data_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic                  sat_flag,
  output logic                  busy,
  output logic [1:0]            o_dbg_state
);

  // Handshake: a beat transfers on a cycle with in_valid && in_ready; the result transfers on a
  // cycle with out_valid && out_ready, and out_valid/out_data/sat_flag are held stable until then.

  localparam int PW = 2 * DW;
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     r_state;
  logic [LEN_W-1:0]           r_rem;
  logic                       r_mode;
  logic                       r_in_ready;
  logic                       r_busy;
  logic                       r_out_valid;
  logic [ACC_W-1:0]           r_out_data;
  logic                       r_out_sat;

  logic                       r_s1_v;
  logic [LANES-1:0][PW-1:0]   r_s1_prod;
  logic                       r_s2_v;
  logic [ACC_W-1:0]           r_s2_sum;
  logic [ACC_W-1:0]           r_acc;
  logic                       r_sat;

  logic                       w_accept;
  logic                       w_start_job;
  logic [LANES-1:0][PW-1:0]   w_prod;
  logic [ACC_W-1:0]           w_sum;
  logic [ACC_W:0]             w_new;
  logic                       w_ovf;
  logic [ACC_W-1:0]           w_acc_next;

  assign w_accept    = in_valid && r_in_ready;
  assign w_start_job = (r_state == S_IDLE) && start && (acc_len != '0);

  // Operands are extended to PW bits per mode; the low PW bits of the product are exact either way.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [PW-1:0] w_ea;
    logic [PW-1:0] w_eb;
    assign w_ea = {{DW{r_mode & data_a[gi*DW+DW-1]}}, data_a[gi*DW +: DW]};
    assign w_eb = {{DW{r_mode & data_b[gi*DW+DW-1]}}, data_b[gi*DW +: DW]};
    assign w_prod[gi] = w_ea * w_eb;
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      w_sum = w_sum + {{(ACC_W-PW){r_mode & r_s1_prod[i][PW-1]}}, r_s1_prod[i]};
    end
  end

  // One guard bit: signed overflow shows as the top two bits disagreeing, unsigned as a carry out.
  always_comb begin
    w_new      = {r_mode & r_acc[ACC_W-1], r_acc} + {r_mode & r_s2_sum[ACC_W-1], r_s2_sum};
    w_ovf      = 1'b0;
    w_acc_next = w_new[ACC_W-1:0];
    if (r_mode) begin
      if (w_new[ACC_W] != w_new[ACC_W-1]) begin
        w_ovf      = 1'b1;
        w_acc_next = w_new[ACC_W] ? SMIN : SMAX;
      end
    end else if (w_new[ACC_W]) begin
      w_ovf      = 1'b1;
      w_acc_next = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v    <= 1'b0;
      r_s1_prod <= '0;
      r_s2_v    <= 1'b0;
      r_s2_sum  <= '0;
      r_acc     <= '0;
      r_sat     <= 1'b0;
    end else begin
      r_s1_v <= w_accept;
      if (w_accept) r_s1_prod <= w_prod;
      r_s2_v <= r_s1_v;
      if (r_s1_v) r_s2_sum <= w_sum;
      if (w_start_job) begin
        r_acc <= '0;
        r_sat <= 1'b0;
      end else if (r_s2_v) begin
        r_acc <= w_acc_next;
        r_sat <= r_sat | w_ovf;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rem       <= '0;
      r_mode      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy <= 1'b1;
            if (acc_len != '0) begin
              r_rem      <= acc_len;
              r_mode     <= signed_mode;
              r_in_ready <= 1'b1;
              r_state    <= S_RUN;
            end else begin
              r_out_valid <= 1'b1;
              r_out_data  <= '0;
              r_out_sat   <= 1'b0;
              r_state     <= S_DONE;
            end
          end
        end
        S_RUN: begin
          if (w_accept) begin
            r_rem <= r_rem - LEN_W'(1);
            if (r_rem == LEN_W'(1)) begin
              r_in_ready <= 1'b0;
              r_state    <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // With S1 and S2 empty the accumulator already holds the last beat.
          if (!r_s1_v && !r_s2_v) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_acc;
            r_out_sat   <= r_sat;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign out_data    = r_out_data;
  assign sat_flag    = r_out_sat;
  assign busy        = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mac_dot_pipe.sv
// Bench for mac_dot_pipe (ACC_W=36): directed jobs plus randomized jobs, scored against a
// plain-integer model of the dot product with clamping.
module tb_mac_dot_pipe;
  localparam int DW    = 16;
  localparam int LANES = 4;
  localparam int ACC_W = 36;
  localparam int LEN_W = 8;
  localparam int BW    = LANES * DW;

  logic             clk;
  logic             rst;
  logic             start;
  logic             signed_mode;
  logic [LEN_W-1:0] acc_len;
  logic             in_valid;
  logic             in_ready;
  logic [BW-1:0]    data_a;
  logic [BW-1:0]    data_b;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             sat_flag;
  logic             busy;
  logic [1:0]       dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [ACC_W-1:0] exp_q[$];
  logic             exp_sat_q[$];
  logic [BW-1:0]    beat_a[$];
  logic [BW-1:0]    beat_b[$];

  mac_dot_pipe #(.DW(DW), .LANES(LANES), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .acc_len(acc_len),
    .in_valid(in_valid), .in_ready(in_ready), .data_a(data_a), .data_b(data_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sat_flag(sat_flag), .busy(busy), .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer dot product per beat, then clamp to the representable range.
  task automatic model_job(input bit mode, output logic [ACC_W-1:0] res, output logic sat);
    longint acc;
    longint s;
    longint maxs;
    longint mins;
    longint maxu;
    acc  = 0;
    sat  = 1'b0;
    maxs = (longint'(1) <<< (ACC_W-1)) - 1;
    mins = -(longint'(1) <<< (ACC_W-1));
    maxu = (longint'(1) <<< ACC_W) - 1;
    foreach (beat_a[k]) begin
      s = 0;
      for (int l = 0; l < LANES; l++) begin
        logic [DW-1:0] va;
        logic [DW-1:0] vb;
        va = beat_a[k][l*DW +: DW];
        vb = beat_b[k][l*DW +: DW];
        if (mode) s += longint'($signed(va)) * longint'($signed(vb));
        else      s += longint'(va) * longint'(vb);
      end
      acc += s;
      if (mode) begin
        if (acc > maxs) begin acc = maxs; sat = 1'b1; end
        if (acc < mins) begin acc = mins; sat = 1'b1; end
      end else if (acc > maxu) begin
        acc = maxu; sat = 1'b1;
      end
    end
    res = acc[ACC_W-1:0];
  endtask

  // Driver: runs one job from beat_a/beat_b. valid_pct<0 means in_valid toggles 1,0,1,0.
  task automatic run_job(input bit mode, input int len, input int valid_pct, input int hold,
                         input bit poke_start, output logic [ACC_W-1:0] got, output logic got_sat);
    logic [ACC_W-1:0] e;
    logic             es;
    int idx;
    int cyc;
    int lat;
    if (len > 0) model_job(mode, e, es);
    else begin e = '0; es = 1'b0; end
    exp_q.push_back(e);
    exp_sat_q.push_back(es);

    @(negedge clk);
    start = 1'b1; signed_mode = mode; acc_len = LEN_W'(len);
    @(negedge clk);
    start = 1'b0; signed_mode = ~mode; acc_len = LEN_W'($urandom_range(255));
    if (len == 0) begin
      check_eq("zero_len_valid", 64'(out_valid), 64'd1);
      check_eq("zero_len_in_ready", 64'(in_ready), 64'd0);
    end else begin
      check_eq("run_busy", 64'(busy), 64'd1);
      idx = 0;
      cyc = 0;
      while (idx < len && cyc < 5000) begin
        if (valid_pct < 0) in_valid = (cyc % 2 == 0);
        else               in_valid = ($urandom_range(99) < valid_pct);
        if (in_valid) begin
          data_a = beat_a[idx];
          data_b = beat_b[idx];
        end else begin
          data_a = {$urandom, $urandom};
          data_b = {$urandom, $urandom};
        end
        start = poke_start && (cyc == 1);
        if (in_valid && in_ready) idx++;
        @(negedge clk);
        cyc++;
      end
      check_eq("beats_accepted", 64'(idx), 64'(len));
      in_valid = 1'b0; start = 1'b0;
      data_a = {$urandom, $urandom};
      data_b = {$urandom, $urandom};
      check_eq("in_ready_drop", 64'(in_ready), 64'd0);
      lat = 1;
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check_eq("latency", 64'(lat), 64'd4);
    end

    got     = out_data;
    got_sat = sat_flag;
    for (int h = 0; h < hold; h++) begin
      check_eq("hold_valid", 64'(out_valid), 64'd1);
      check_eq("hold_data", 64'(out_data), 64'(got));
      check_eq("hold_sat", 64'(sat_flag), 64'(got_sat));
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    check_eq("out_valid", 64'(out_valid), 64'd1);
    check_eq("result", 64'(got), 64'(exp_q.pop_front()));
    check_eq("sat_flag", 64'(got_sat), 64'(exp_sat_q.pop_front()));
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("valid_drop", 64'(out_valid), 64'd0);
    check_eq("idle_busy", 64'(busy), 64'd0);
  endtask

  task automatic fill_const(input int len, input logic [BW-1:0] a, input logic [BW-1:0] b);
    beat_a.delete(); beat_b.delete();
    for (int k = 0; k < len; k++) begin
      beat_a.push_back(a);
      beat_b.push_back(b);
    end
  endtask

  task automatic fill_rand(input int len);
    beat_a.delete(); beat_b.delete();
    for (int k = 0; k < len; k++) begin
      beat_a.push_back({$urandom, $urandom});
      beat_b.push_back({$urandom, $urandom});
    end
  endtask

  logic [ACC_W-1:0] r_got;
  logic             r_got_sat;

  initial begin
    rst = 1'b1; start = 1'b0; signed_mode = 1'b0; acc_len = '0;
    in_valid = 1'b0; data_a = '0; data_b = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_out_valid", 64'(out_valid), 64'd0);
    check_eq("reset_in_ready", 64'(in_ready), 64'd0);
    check_eq("reset_out_data", 64'(out_data), 64'd0);
    check_eq("reset_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    fill_const(3, {4{16'd2}}, {4{16'd3}});
    run_job(1'b0, 3, 100, 0, 1'b0, r_got, r_got_sat);
    check_eq("dir_unsigned_72", 64'(r_got), 64'd72);

    beat_a.delete(); beat_b.delete();
    beat_a.push_back({16'd4, 16'hFFFD, 16'd2, 16'hFFFF});
    beat_b.push_back({4{16'd5}});
    beat_a.push_back({4{16'hFFFF}});
    beat_b.push_back({4{16'hFFFF}});
    run_job(1'b1, 2, 100, 0, 1'b0, r_got, r_got_sat);
    check_eq("dir_signed_14", 64'(r_got), 64'd14);

    fill_rand(4);
    run_job(1'b0, 4, -1, 5, 1'b0, r_got, r_got_sat);

    fill_const(255, {4{16'h8000}}, {4{16'h8000}});
    run_job(1'b1, 255, 100, 1, 1'b0, r_got, r_got_sat);
    check_eq("sat_signed_max", 64'(r_got), 64'h7_FFFF_FFFF);
    check_eq("sat_signed_flag", 64'(r_got_sat), 64'd1);

    fill_const(255, {4{16'hFFFF}}, {4{16'hFFFF}});
    run_job(1'b0, 255, 100, 1, 1'b0, r_got, r_got_sat);
    check_eq("sat_unsigned_ones", 64'(r_got), 64'hF_FFFF_FFFF);
    check_eq("sat_unsigned_flag", 64'(r_got_sat), 64'd1);

    beat_a.delete(); beat_b.delete();
    run_job(1'b0, 0, 100, 2, 1'b0, r_got, r_got_sat);
    check_eq("zero_len_data", 64'(r_got), 64'd0);

    fill_rand(6);
    run_job(1'b1, 6, 100, 0, 1'b1, r_got, r_got_sat);

    // Reset mid-job: two of five beats in, then abort.
    fill_const(5, {4{16'd7}}, {4{16'd9}});
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; acc_len = LEN_W'(5);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; data_a = beat_a[0]; data_b = beat_b[0];
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_in_ready", 64'(in_ready), 64'd0);
    check_eq("abort_out_valid", 64'(out_valid), 64'd0);
    check_eq("abort_out_data", 64'(out_data), 64'd0);
    check_eq("abort_sat", 64'(sat_flag), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_state_idle", 64'(dbg_state), 64'd0);
    fill_const(1, {4{16'd1}}, {4{16'd1}});
    run_job(1'b0, 1, 100, 0, 1'b0, r_got, r_got_sat);
    check_eq("after_reset_4", 64'(r_got), 64'd4);

    for (int j = 0; j < 12; j++) begin
      int len;
      len = $urandom_range(20, 1);
      fill_rand(len);
      run_job(1'($urandom_range(1)), len, $urandom_range(100, 50), $urandom_range(3), 1'($urandom_range(1)),
              r_got, r_got_sat);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
